// File: rtl/series_datapath.sv
// Datapath for the series-evaluation controller: holds operand X, running
// term M, accumulator T and a saturating term counter; multiplies in signed
// fixed point against a reciprocal-coefficient ROM and captures the final sum.
module series_datapath #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 14,
    parameter int MAX_COUNT = 12,
    parameter int CW        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    rst_w,
    input  logic                    load_x,
    input  logic                    load_m,
    input  logic                    load_t,
    input  logic                    sel_x,
    input  logic                    sel_1,
    input  logic                    sel_2,
    input  logic                    sel_t,
    input  logic                    mode,
    input  logic                    counter_en,
    input  logic                    done,
    output logic                    gt,
    output logic                    lsb_counter,
    output logic signed [WIDTH-1:0] result,
    output logic                    result_valid
);

    localparam int DEPTH = 2 ** CW;
    localparam longint unsigned ONE = 64'd1 << FRAC;

    logic signed [WIDTH-1:0]   x_reg;
    logic signed [WIDTH-1:0]   m_reg;
    logic signed [WIDTH-1:0]   t_reg;
    logic        [CW-1:0]      cnt_reg;
    logic signed [WIDTH-1:0]   result_reg;
    logic                      valid_reg;

    logic signed [WIDTH-1:0]   coef_rom [DEPTH];
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   m_next;
    logic signed [WIDTH-1:0]   t_next;

    // Reciprocal table 1/(k+1) in Q(FRAC), fixed at elaboration.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coef
            assign coef_rom[gi] = WIDTH'(ONE / longint'(gi + 1));
        end
    endgenerate

    // Operand selection and full-width product; the kept slice is an
    // arithmetic right shift by FRAC (floor toward -inf), upper bits wrap.
    always_comb begin
        mul_a  = sel_1 ? m_reg : x_reg;
        mul_b  = sel_2 ? coef_rom[cnt_reg] : x_reg;
        prod   = mul_a * mul_b;
        m_next = WIDTH'(prod >>> FRAC);
    end

    // Value T takes this edge; done captures this so a simultaneous update
    // is seen in the result.
    always_comb begin
        t_next = t_reg;
        if (load_t) begin
            if (sel_t)
                t_next = mode ? (t_reg - m_reg) : (t_reg + m_reg);
            else
                t_next = x_in;
        end
    end

    // Register file; rst_w wipes working state but leaves X and result alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg      <= '0;
            m_reg      <= '0;
            t_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            // X reads the pre-edge M, so a concurrent load_m does not leak in.
            if (load_x)
                x_reg <= sel_x ? m_reg : x_in;
            if (rst_w) begin
                m_reg     <= '0;
                t_reg     <= '0;
                cnt_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                if (load_m)
                    m_reg <= m_next;
                t_reg <= t_next;
                if (counter_en && (cnt_reg != {CW{1'b1}}))
                    cnt_reg <= cnt_reg + 1'b1;
                if (done) begin
                    result_reg <= t_next;
                    valid_reg  <= 1'b1;
                end
            end
        end
    end

    assign gt           = (cnt_reg >= CW'(MAX_COUNT));
    assign lsb_counter  = cnt_reg[0];
    assign result       = result_reg;
    assign result_valid = valid_reg;

endmodule

// File: tb/tb_series_datapath.sv
// Self-checking bench for series_datapath: directed walk through the series
// steps with literal expectations, then randomized strobes against an
// integer-arithmetic model of the datapath.
module tb_series_datapath;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] x_in = '0;
    logic               rst_w = 0, load_x = 0, load_m = 0, load_t = 0;
    logic               sel_x = 0, sel_1 = 0, sel_2 = 0, sel_t = 0, mode = 0;
    logic               counter_en = 0, done = 0;
    logic               gt, lsb_counter, result_valid;
    logic signed [15:0] result;

    int errors = 0;
    int checks = 0;

    // Model state (plain integers)
    int mx = 0, mm = 0, mt = 0, mc = 0, mres = 0, mval = 0;

    series_datapath dut (
        .clk(clk), .rst(rst), .x_in(x_in), .rst_w(rst_w),
        .load_x(load_x), .load_m(load_m), .load_t(load_t),
        .sel_x(sel_x), .sel_1(sel_1), .sel_2(sel_2), .sel_t(sel_t),
        .mode(mode), .counter_en(counter_en), .done(done),
        .gt(gt), .lsb_counter(lsb_counter),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic int wrap16(input longint v);
        return int'(shortint'(v));
    endfunction

    function automatic int fx_mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return wrap16(p >>> 14);
    endfunction

    function automatic int coef(input int k);
        return 16384 / (k + 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every observable against the model.
    task automatic compare_all();
        check("X", int'($signed(dut.x_reg)), mx);
        check("M", int'($signed(dut.m_reg)), mm);
        check("T", int'($signed(dut.t_reg)), mt);
        check("counter", int'(dut.cnt_reg), mc);
        check("gt", int'(gt), (mc >= 12) ? 1 : 0);
        check("lsb_counter", int'(lsb_counter), mc % 2);
        check("result", int'(result), mres);
        check("result_valid", int'(result_valid), mval);
    endtask

    task automatic model_reset();
        mx = 0; mm = 0; mt = 0; mc = 0; mres = 0; mval = 0;
    endtask

    task automatic clear_strobes();
        rst_w = 0; load_x = 0; load_m = 0; load_t = 0; sel_x = 0; sel_1 = 0;
        sel_2 = 0; sel_t = 0; mode = 0; counter_en = 0; done = 0;
    endtask

    // Advance one clock: compute the model's next state from current inputs,
    // clock the DUT, then compare just after the edge.
    task automatic tick();
        int nx, nm, nt, nc, a, b;
        nx = load_x ? (sel_x ? mm : int'(x_in)) : mx;
        a  = sel_1 ? mm : mx;
        b  = sel_2 ? coef(mc) : mx;
        nm = load_m ? fx_mul(a, b) : mm;
        nt = !load_t ? mt : (!sel_t ? int'(x_in) : (mode ? wrap16(mt - mm) : wrap16(mt + mm)));
        nc = (counter_en && mc < 15) ? mc + 1 : mc;
        @(posedge clk);
        #1;
        mx = nx;
        if (rst_w) begin
            mm = 0; mt = 0; mc = 0; mval = 0;
        end else begin
            mm = nm; mt = nt; mc = nc;
            if (done) begin
                mres = nt; mval = 1;
            end
        end
        compare_all();
        $display("cycle: X=%0d M=%0d T=%0d cnt=%0d result=%0d valid=%0d",
                 mx, mm, mt, mc, mres, mval);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 0;
        check("reset_result_lit", int'(result), 0);

        // Init and square
        clear_strobes();
        x_in = 16'sd8192; load_x = 1; load_t = 1;
        tick();
        check("init_X_lit", int'($signed(dut.x_reg)), 8192);
        check("init_T_lit", int'($signed(dut.t_reg)), 8192);
        clear_strobes(); load_m = 1;
        tick();
        check("square_M_lit", int'($signed(dut.m_reg)), 4096);
        clear_strobes(); load_x = 1; sel_x = 1;
        tick();
        check("x_from_m_lit", int'($signed(dut.x_reg)), 4096);

        // Counter / ROM
        clear_strobes(); counter_en = 1;
        repeat (3) tick();
        check("cnt3_lsb_lit", int'(lsb_counter), 1);
        clear_strobes(); load_m = 1; sel_1 = 1; sel_2 = 1;
        tick();
        check("m_coef3_lit", int'($signed(dut.m_reg)), 1024);

        // Subtract with done, then add
        clear_strobes(); load_t = 1; sel_t = 1; mode = 1; done = 1;
        tick();
        check("sub_T_lit", int'($signed(dut.t_reg)), 7168);
        check("sub_result_lit", int'(result), 7168);
        check("sub_valid_lit", int'(result_valid), 1);
        clear_strobes(); load_t = 1; sel_t = 1; mode = 0;
        tick();
        check("add_T_lit", int'($signed(dut.t_reg)), 8192);
        check("add_result_hold_lit", int'(result), 7168);

        // gt boundary and saturation (counter at 3)
        clear_strobes(); counter_en = 1;
        repeat (8) tick();
        check("gt_at_11_lit", int'(gt), 0);
        tick();
        check("gt_at_12_lit", int'(gt), 1);
        repeat (4) tick();
        check("cnt_sat_lit", int'(dut.cnt_reg), 15);

        // rst_w priority over load_t / counter_en / done
        clear_strobes(); rst_w = 1; load_t = 1; sel_t = 0; x_in = 16'sd555;
        counter_en = 1; done = 1;
        tick();
        check("prio_T_lit", int'($signed(dut.t_reg)), 0);
        check("prio_cnt_lit", int'(dut.cnt_reg), 0);
        check("prio_gt_lit", int'(gt), 0);
        check("prio_valid_lit", int'(result_valid), 0);
        check("prio_result_lit", int'(result), 7168);
        check("prio_X_lit", int'($signed(dut.x_reg)), 4096);

        // Negative floor: M=-1 times coef[1]=8192 stays -1
        clear_strobes(); x_in = -16'sd1; load_x = 1;
        tick();
        clear_strobes(); load_m = 1; sel_2 = 1;   // -1 * 16384 >> 14 = -1
        tick();
        check("neg_M0_lit", int'($signed(dut.m_reg)), -1);
        clear_strobes(); counter_en = 1;
        tick();
        clear_strobes(); load_m = 1; sel_1 = 1; sel_2 = 1;
        tick();
        check("neg_floor_lit", int'($signed(dut.m_reg)), -1);

        // Read-before-write: load_x from M together with load_m
        clear_strobes(); load_x = 1; sel_x = 1; load_m = 1;
        tick();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            clear_strobes();
            x_in       = 16'($urandom);
            rst_w      = ($urandom_range(0, 15) == 0);
            load_x     = 1'($urandom);
            load_m     = 1'($urandom);
            load_t     = 1'($urandom);
            sel_x      = 1'($urandom);
            sel_1      = 1'($urandom);
            sel_2      = 1'($urandom);
            sel_t      = 1'($urandom);
            mode       = 1'($urandom);
            counter_en = ($urandom_range(0, 2) != 0);
            done       = ($urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1;
                #1 model_reset();
                compare_all();
                #1 rst = 0;
            end
        end

        // Asynchronous reset mid-run with T=9216 and a captured result
        clear_strobes(); x_in = 16'sd9216; load_t = 1; done = 1; load_x = 1;
        tick();
        check("pre_rst_T_lit", int'($signed(dut.t_reg)), 9216);
        clear_strobes();
        #2 rst = 1;
        #1;
        check("arst_X_lit", int'($signed(dut.x_reg)), 0);
        check("arst_T_lit", int'($signed(dut.t_reg)), 0);
        check("arst_result_lit", int'(result), 0);
        check("arst_valid_lit", int'(result_valid), 0);
        check("arst_gt_lit", int'(gt), 0);
        check("arst_lsb_lit", int'(lsb_counter), 0);
        model_reset();
        compare_all();
        #1 rst = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
